spin_readout: RTL and testbench

Samples the N asynchronous oscillator taps leaving the coupled-cell array and resolves each oscillator into a binary spin. Each spin is resolved by its phase relationship to oscillator 0, the reference. A run starts on a `start` pulse. The block then flushes its synchronisers and counts per-oscillator mismatches against the reference over a programmable sample window. At the end it publishes an N-bit spin vector with a one-cycle `done` pulse. It sits directly downstream of the array and upstream of the host/annealing controller.

---
 rtl/ising_readout_pkg.sv | 20 ++
 rtl/bit_sync.sv | 37 +++
 rtl/spin_readout.sv | 179 +++++++++++++++++
 tb/tb_spin_readout.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ising_readout_pkg.sv
// ---------------------------------------------------------------------------
// ising_readout_pkg
//   Shared definitions for the spin readout block: the FSM state encoding and
//   default values for the counter width and synchroniser depth.
//   No ports (package).
// ---------------------------------------------------------------------------
package ising_readout_pkg;

  localparam int DEFAULT_CNT_W       = 10;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
//   Single-bit flop-chain synchroniser for one asynchronous oscillator tap.
//   The chain is cleared synchronously while rst_n is low.
//
//   Parameters:
//     STAGES  chain depth (minimum 2)
//   Ports:
//     clk     sole clock
//     rst_n   synchronous active-low clear
//     d_i     asynchronous input bit
//     q_o     synchronised output bit (last chain stage)
// ---------------------------------------------------------------------------
module bit_sync
  import ising_readout_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spin_readout.sv
// ---------------------------------------------------------------------------
// spin_readout
//   Resolves N asynchronous oscillator taps into a binary spin vector. Each
//   oscillator is compared against oscillator 0 (the reference) over a
//   programmable sample window; an oscillator that disagrees with the
//   reference in more than half of the samples is reported as spin 1.
//
//   Optional feature macro: SPIN_READOUT_COUNTS_EN
//     When defined, the raw per-oscillator mismatch counts are also published
//     on mm_counts (slice i = count for oscillator i), latched with spins.
//
//   Parameters:
//     N            number of oscillators/spins (minimum 2)
//     CNT_W        sample window and mismatch counter width
//     SYNC_STAGES  synchroniser depth per tap (minimum 2)
//   Ports:
//     clk          sole clock
//     rst_n        synchronous active-low reset
//     start        run request, only honoured in IDLE
//     window       number of sample cycles, latched on start (0 means 1)
//     osc          raw oscillator taps, asynchronous to clk
//     busy         high while a run is in SETTLE/SAMPLE/DECIDE
//     done         one-cycle pulse when spins has been updated
//     spins_valid  high while spins holds a completed run's result
//     spins        resolved spin vector, bit 0 always 0
//     mm_counts    (SPIN_READOUT_COUNTS_EN only) latched mismatch counts
// ---------------------------------------------------------------------------
module spin_readout
  import ising_readout_pkg::*;
#(
  parameter int N           = 8,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   window,
  input  logic [N-1:0]       osc,
  output logic               busy,
  output logic               done,
  output logic               spins_valid,
`ifdef SPIN_READOUT_COUNTS_EN
  output logic [N*CNT_W-1:0] mm_counts,
`endif
  output logic [N-1:0]       spins
);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SYNC_STAGES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   win_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   mm_q [N];
  logic [CNT_W-1:0]   mm_d [N];
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic [N-1:0]       spins_q;
  logic [N-1:0]       spins_d;
  logic [N-1:0]       s;
  logic [N-1:0]       diff;
`ifdef SPIN_READOUT_COUNTS_EN
  logic [N*CNT_W-1:0] mm_counts_q;
`endif

  for (genvar g = 0; g < N; g++) begin : g_sync
    bit_sync #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (osc[g]),
      .q_o   (s[g])
    );
  end

  // Phase disagreement with the reference; bit 0 is zero by construction.
  assign diff = s ^ {N{s[0]}};

  // Incremented mismatch counts and the majority decision. Doubling the count
  // (one extra bit) turns "more than half the window" into a plain compare;
  // an exact tie resolves to 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mm_d[i]    = mm_q[i] + CNT_W'(diff[i]);
      spins_d[i] = ({mm_q[i], 1'b0} > {1'b0, win_q});
    end
    spins_d[0] = 1'b0;
  end

  // Run sequencer. cnt_q is reused as the SETTLE and SAMPLE cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        mm_q[i] <= '0;
      end
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      spins_q <= '0;
`ifdef SPIN_READOUT_COUNTS_EN
      mm_counts_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            win_q <= (window == '0) ? ONE : window;
            cnt_q <= '0;
            for (int i = 0; i < N; i++) begin
              mm_q[i] <= '0;
            end
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end

        ST_SAMPLE: begin
          for (int i = 0; i < N; i++) begin
            mm_q[i] <= mm_d[i];
          end
          if (cnt_q == win_q - ONE) begin
            cnt_q   <= '0;
            state_q <= ST_DECIDE;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end

        ST_DECIDE: begin
          spins_q <= spins_d;
`ifdef SPIN_READOUT_COUNTS_EN
          for (int i = 0; i < N; i++) begin
            mm_counts_q[i*CNT_W +: CNT_W] <= mm_q[i];
          end
`endif
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          state_q <= ST_DONE;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign spins_valid = valid_q;
  assign spins       = spins_q;
`ifdef SPIN_READOUT_COUNTS_EN
  assign mm_counts   = mm_counts_q;
`endif

endmodule

// File: tb/tb_spin_readout.sv
// ---------------------------------------------------------------------------
// tb_spin_readout
//   Self-checking bench for spin_readout (N=4, CNT_W=10, SYNC_STAGES=2).
//   A run's expected spins are computed from the osc values presented in the
//   window cycles following the accepted start: spin i is 1 when oscillator i
//   disagrees with oscillator 0 in more than half of those samples.
// ---------------------------------------------------------------------------
module tb_spin_readout;

  localparam int TN = 4;
  localparam int TW = 10;
  localparam int TS = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [TW-1:0]   window;
  logic [TN-1:0]   osc;
  logic            busy;
  logic            done;
  logic            spinsValid;
  logic [TN-1:0]   spins;
`ifdef SPIN_READOUT_COUNTS_EN
  logic [TN*TW-1:0] mmCounts;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [TN-1:0] pat [64];
  logic [TN-1:0] lastSpins;

  always #5 clk = ~clk;

  spin_readout #(
    .N           (TN),
    .CNT_W       (TW),
    .SYNC_STAGES (TS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .window      (window),
    .osc         (osc),
    .busy        (busy),
    .done        (done),
    .spins_valid (spinsValid),
`ifdef SPIN_READOUT_COUNTS_EN
    .mm_counts   (mmCounts),
`endif
    .spins       (spins)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // mode 0: all taps follow one square wave (period 10 cycles)
  // mode 1: tap 2 inverted
  // mode 2: tap 1 inverted during the first 8 samples only
  task automatic fillSquare(input int mode);
    logic sq;
    logic [TN-1:0] p;
    for (int k = 0; k < 64; k++) begin
      sq = (((k + 2) / 5) % 2) == 1;
      p = {TN{sq}};
      if (mode == 1) p[2] = ~sq;
      if (mode == 2 && k < 8) p[1] = ~sq;
      pat[k] = p;
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < 64; k++) pat[k] = TN'($urandom);
  endtask

  // One complete run starting from IDLE, aligned 1 time unit after a posedge.
  task automatic applyStimulus(input string name, input logic [TW-1:0] win,
                               input bit ignoredStarts);
    int w;
    int mmExp [TN];
    logic [TN-1:0] spinExp;
    logic [TN*TW-1:0] countsExp;
    int doneAt;
    w = (win == '0) ? 1 : int'(win);
    doneAt = TS + w + 2;
    spinExp = '0;
    countsExp = '0;
    for (int i = 0; i < TN; i++) begin
      mmExp[i] = 0;
      for (int k = 0; k < w; k++) mmExp[i] += int'(pat[k][i] ^ pat[k][0]);
      spinExp[i] = (2 * mmExp[i]) > w;
      countsExp[i*TW +: TW] = TW'(mmExp[i]);
    end

    start  = 1'b1;
    window = win;
    @(posedge clk);
    #1;
    for (int c = 1; c <= doneAt + 1; c++) begin
      osc    = (c <= w) ? pat[c-1] : TN'($urandom);
      window = TW'($urandom);
      start  = ignoredStarts && (c == TS + 2 || c == doneAt);
      @(negedge clk);
      checkOutput($sformatf("%s busy c%0d", name, c), 64'(busy), 64'(c < doneAt));
      checkOutput($sformatf("%s done c%0d", name, c), 64'(done), 64'(c == doneAt));
      checkOutput($sformatf("%s valid c%0d", name, c), 64'(spinsValid), 64'(c >= doneAt));
      if (c < doneAt) begin
        checkOutput($sformatf("%s oldSpins c%0d", name, c), 64'(spins), 64'(lastSpins));
      end else begin
        checkOutput($sformatf("%s spins c%0d", name, c), 64'(spins), 64'(spinExp));
`ifdef SPIN_READOUT_COUNTS_EN
        checkOutput($sformatf("%s mmCounts c%0d", name, c), 64'(mmCounts), 64'(countsExp));
`endif
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    lastSpins = spinExp;
    // Idle stays idle: no second run from the ignored pulses.
    repeat (3) begin
      @(negedge clk);
      checkOutput($sformatf("%s idleBusy", name), 64'(busy), 64'(0));
      checkOutput($sformatf("%s idleDone", name), 64'(done), 64'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic abortRun();
    bit sawActivity;
    start  = 1'b1;
    window = TW'(20);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (TS + 1) begin
      osc = TN'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort busyBefore", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'(0));
    checkOutput("abort spins", 64'(spins), 64'(0));
    checkOutput("abort done", 64'(done), 64'(0));
    checkOutput("abort valid", 64'(spinsValid), 64'(0));
    lastSpins = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sawActivity = 1'b0;
    repeat (30) begin
      osc = TN'($urandom);
      @(negedge clk);
      if (done || busy) sawActivity = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("abort noDone", 64'(sawActivity), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    window = '0;
    osc    = '0;
    lastSpins = '0;

    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      osc = ~osc;
      @(negedge clk);
      checkOutput($sformatf("reset busy c%0d", c), 64'(busy), 64'(0));
      checkOutput($sformatf("reset done c%0d", c), 64'(done), 64'(0));
      checkOutput($sformatf("reset valid c%0d", c), 64'(spinsValid), 64'(0));
      checkOutput($sformatf("reset spins c%0d", c), 64'(spins), 64'(0));
`ifdef SPIN_READOUT_COUNTS_EN
      checkOutput($sformatf("reset mmCounts c%0d", c), 64'(mmCounts), 64'(0));
`endif
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fillSquare(0);
    applyStimulus("inPhase", TW'(16), 1'b0);
    fillSquare(1);
    applyStimulus("antiPhase", TW'(16), 1'b0);
    fillSquare(2);
    applyStimulus("tie", TW'(16), 1'b0);
    fillRandom();
    applyStimulus("windowZero", TW'(0), 1'b0);
    fillRandom();
    applyStimulus("ignoredStart", TW'(12), 1'b1);

    for (int r = 0; r < 6; r++) begin
      fillRandom();
      applyStimulus($sformatf("random%0d", r), TW'($urandom_range(40, 1)), 1'b0);
    end

    fillSquare(1);
    applyStimulus("beforeAbort", TW'(10), 1'b0);
    abortRun();
    fillRandom();
    applyStimulus("afterAbort", TW'(9), 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
